// File: rtl/image_fetch_sequencer.sv
// rtl/image_fetch_sequencer.sv - raster-order chunk fetcher from image memory to the vector datapath
//
// Walks the image from top-left to bottom-right in LANES-pixel chunks. Each
// memory read vector is captured into vec_data and streamed to the consumer
// over a valid/ready handshake. It sustains one chunk per cycle.
//
// Ports:
//   CLK, RSTn            clock (rising edge), asynchronous active-low reset
//   start, abort         control unit: start a full scan / cancel the scan
//   mem_addr             pixel address of the chunk presented to memory
//   mem_rd[255:0]        16 lanes x 16 bits, lane i = pixel mem_addr+i
//   vec_data[255:0]      captured chunk, lanes LANES..15 forced to zero
//   vec_valid/vec_ready  stream handshake
//   vec_row, vec_col     coordinates of lane 0 of vec_data
//   vec_last             vec_data is the final chunk of the image
//   busy                 scan in progress (FETCH or STREAM)
//   done                 one-cycle pulse after the final chunk is accepted
module image_fetch_sequencer #(
    parameter int IMAGE_WIDTH  = 96,
    parameter int IMAGE_HEIGHT = 96,
    parameter int LANES        = 8,
    parameter int BASE_ADDR    = 0
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         start,
    input  logic         abort,
    output logic [15:0]  mem_addr,
    input  logic [255:0] mem_rd,
    output logic [255:0] vec_data,
    output logic         vec_valid,
    input  logic         vec_ready,
    output logic [15:0]  vec_row,
    output logic [15:0]  vec_col,
    output logic         vec_last,
    output logic         busy,
    output logic         done
);

    localparam logic [15:0] STEP     = 16'(LANES);
    localparam logic [15:0] BASE     = 16'(BASE_ADDR);
    localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);
    localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - LANES);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

    state_t         state_q, state_d;
    logic [15:0]    addr_q, addr_d;
    // Coordinates of the chunk currently addressed by addr_q (the next one to load).
    logic [15:0]    nrow_q, nrow_d;
    logic [15:0]    ncol_q, ncol_d;
    logic [255:0]   data_q, data_d;
    logic           valid_q, valid_d;
    logic [15:0]    row_q, row_d;
    logic [15:0]    col_q, col_d;
    logic           last_q, last_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           load;
    logic [255:0]   captured;

    always_comb begin
        captured = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < LANES) begin
                captured[16*i +: 16] = mem_rd[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        nrow_d  = nrow_q;
        ncol_d  = ncol_q;
        data_d  = data_q;
        valid_d = valid_q;
        row_d   = row_q;
        col_d   = col_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = done_q;
        load    = 1'b0;

        if (abort) begin
            // Abort wins over everything, including a handshake in the same cycle.
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            addr_d  = BASE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FETCH;
                        addr_d  = BASE;
                        nrow_d  = '0;
                        ncol_d  = '0;
                        busy_d  = 1'b1;
                    end
                end
                FETCH: begin
                    load    = 1'b1;
                    state_d = STREAM;
                end
                STREAM: begin
                    if (valid_q && vec_ready) begin
                        if (last_q) begin
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (load) begin
                data_d  = captured;
                valid_d = 1'b1;
                row_d   = nrow_q;
                col_d   = ncol_q;
                last_d  = (nrow_q == LAST_ROW) && (ncol_q == LAST_COL);
                addr_d  = addr_q + STEP;
                if (ncol_q == LAST_COL) begin
                    ncol_d = '0;
                    nrow_d = nrow_q + 16'd1;
                end else begin
                    ncol_d = ncol_q + STEP;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            addr_q  <= BASE;
            nrow_q  <= '0;
            ncol_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            nrow_q  <= nrow_d;
            ncol_q  <= ncol_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            row_q   <= row_d;
            col_q   <= col_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_addr  = addr_q;
    assign vec_data  = data_q;
    assign vec_valid = valid_q;
    assign vec_row   = row_q;
    assign vec_col   = col_q;
    assign vec_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_image_fetch_sequencer.sv
// tb/tb_image_fetch_sequencer.sv - self-checking bench for image_fetch_sequencer
module tb_image_fetch_sequencer;

    localparam int W    = 96;
    localparam int H    = 96;
    localparam int L    = 8;
    localparam int BASE = 0;
    localparam int CPR  = W / L;
    localparam int N    = CPR * H;

    logic         CLK = 1'b0;
    logic         RSTn;
    logic         start, abort, vec_ready;
    logic [15:0]  mem_addr, vec_row, vec_col;
    logic [255:0] mem_rd, vec_data;
    logic         vec_valid, vec_last, busy, done;

    logic         start_s, abort_s, vec_ready_s;
    logic [15:0]  mem_addr_s, vec_row_s, vec_col_s;
    logic [255:0] mem_rd_s, vec_data_s;
    logic         vec_valid_s, vec_last_s, busy_s, done_s;

    logic [7:0]   mem [0:65535];
    int           checks = 0;
    int           errors = 0;

    always #5 CLK = ~CLK;

    image_fetch_sequencer dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .abort(abort),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .vec_data(vec_data),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_row(vec_row),
        .vec_col(vec_col), .vec_last(vec_last), .busy(busy), .done(done)
    );

    image_fetch_sequencer #(.IMAGE_WIDTH(16), .IMAGE_HEIGHT(2), .LANES(8), .BASE_ADDR(100)) dut_s (
        .CLK(CLK), .RSTn(RSTn), .start(start_s), .abort(abort_s),
        .mem_addr(mem_addr_s), .mem_rd(mem_rd_s), .vec_data(vec_data_s),
        .vec_valid(vec_valid_s), .vec_ready(vec_ready_s), .vec_row(vec_row_s),
        .vec_col(vec_col_s), .vec_last(vec_last_s), .busy(busy_s), .done(done_s)
    );

    // Memory read port: all 16 lanes carry real memory data.
    always_comb begin
        mem_rd   = '0;
        mem_rd_s = '0;
        for (int i = 0; i < 16; i++) begin
            mem_rd[16*i +: 16]   = {8'h00, mem[16'(mem_addr + 16'(i))]};
            mem_rd_s[16*i +: 16] = {8'h00, mem[16'(mem_addr_s + 16'(i))]};
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected chunk: L pixels starting at addr, upper lanes zero.
    function automatic logic [255:0] model_vec(input int addr);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < L; i++) begin
            v[16*i +: 16] = {8'h00, mem[16'(addr + i)]};
        end
        return v;
    endfunction

    // mode 0: ready always 1, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic scan(input int mode, input int abort_at, input int start_at);
        int k;
        int it;
        bit finished;
        k = 0;
        it = 0;
        finished = 1'b0;
        start = 1'b1;
        vec_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        check("fetch_valid", vec_valid, 0);
        check("fetch_busy", busy, 1);
        check("fetch_addr", mem_addr, 16'(BASE));
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            @(negedge CLK);
            start = 1'b0;
            abort = 1'b0;
            if (k < N) begin
                check("valid", vec_valid, 1);
                check("data", vec_data, model_vec(BASE + k * L));
                check("row", vec_row, 16'(k / CPR));
                check("col", vec_col, 16'((k % CPR) * L));
                check("last", vec_last, k == N - 1);
                check("busy", busy, 1);
                check("done_early", done, 0);
                check("addr", mem_addr, 16'(BASE + (k + 1) * L));
                case (mode)
                    0: vec_ready = 1'b1;
                    1: vec_ready = (it % 3 == 0);
                    default: vec_ready = 1'($urandom_range(0, 1));
                endcase
                it++;
                if (k == abort_at) begin
                    abort = 1'b1;
                    vec_ready = 1'b1;
                    @(negedge CLK);
                    abort = 1'b0;
                    check("abort_valid", vec_valid, 0);
                    check("abort_busy", busy, 0);
                    for (int j = 0; j < 4; j++) begin
                        check("abort_no_done", done, 0);
                        @(negedge CLK);
                    end
                    check("abort_idle_valid", vec_valid, 0);
                    finished = 1'b1;
                end else begin
                    if (k == start_at) start = 1'b1;
                    if (vec_ready) k++;
                end
            end else begin
                check("done_pulse", done, 1);
                check("done_valid", vec_valid, 0);
                check("done_busy", busy, 0);
                vec_ready = 1'b0;
                @(negedge CLK);
                check("done_once", done, 0);
                check("idle_busy", busy, 0);
                finished = 1'b1;
            end
        end
        vec_ready = 1'b0;
        check("scan_finished", finished, 1);
        if (mode == 0 && abort_at < 0) check("throughput", it, N);
    endtask

    task automatic scan_small();
        int ea[4] = '{100, 108, 116, 124};
        int er[4] = '{0, 0, 1, 1};
        int ec[4] = '{0, 8, 0, 8};
        start_s = 1'b1;
        @(negedge CLK);
        start_s = 1'b0;
        vec_ready_s = 1'b1;
        check("s_fetch_addr", mem_addr_s, 16'd100);
        check("s_fetch_valid", vec_valid_s, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("s_valid", vec_valid_s, 1);
            check("s_data", vec_data_s, model_vec(ea[k]));
            check("s_row", vec_row_s, 16'(er[k]));
            check("s_col", vec_col_s, 16'(ec[k]));
            check("s_last", vec_last_s, k == 3);
            check("s_addr", mem_addr_s, 16'(ea[k] + 8));
        end
        @(negedge CLK);
        check("s_done", done_s, 1);
        check("s_done_valid", vec_valid_s, 0);
        @(negedge CLK);
        check("s_done_once", done_s, 0);
        vec_ready_s = 1'b0;
    endtask

    initial begin
        RSTn = 1'b0;
        start = 1'b0; abort = 1'b0; vec_ready = 1'b0;
        start_s = 1'b0; abort_s = 1'b0; vec_ready_s = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
        repeat (2) @(negedge CLK);
        check("rst_addr", mem_addr, 16'(BASE));
        check("rst_s_addr", mem_addr_s, 16'd100);
        check("rst_valid", vec_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        RSTn = 1'b1;
        @(negedge CLK);

        // Asynchronous reset in the middle of a stream.
        start = 1'b1;
        vec_ready = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (20) @(negedge CLK);
        check("mid_valid", vec_valid, 1);
        check("mid_row", vec_row, 16'(19 / CPR));
        #2 RSTn = 1'b0;
        #1;
        check("arst_valid", vec_valid, 0);
        check("arst_data", vec_data, 0);
        check("arst_row", vec_row, 0);
        check("arst_col", vec_col, 0);
        check("arst_last", vec_last, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_addr", mem_addr, 16'(BASE));
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("idle_valid", vec_valid, 0);
            check("idle_busy", busy, 0);
        end
        vec_ready = 1'b0;

        scan(0, -1, 10);
        scan(1, -1, -1);
        scan(0, 500, -1);

        // start together with abort in IDLE must not start a scan.
        start = 1'b1;
        abort = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 0);
        @(negedge CLK);
        check("sa_busy2", busy, 0);
        check("sa_valid", vec_valid, 0);

        scan(0, -1, -1);

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        scan(2, -1, -1);
        scan_small();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_fetch_sequencer.md
Name: image_fetch_sequencer

Overview:
- Sequencer that walks the 8-bit image memory in 8-pixel chunks, from top-left to bottom-right.
- Drives the memory word address and captures each 16-lane read vector into an output register.
- Streams the vectors to the vector register file / vector ALU over a valid/ready handshake.
- Sits between the control unit (start/abort/done) and the image data memory read port.

Parameters:
- IMAGE_WIDTH, 96, pixels per image row; must be a multiple of LANES.
- IMAGE_HEIGHT, 96, image rows.
- LANES, 8, pixels returned per memory read; lanes LANES..15 are always zero.
- BASE_ADDR, 0, first pixel address of the image in memory.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a full-image scan when idle.
- abort  in  1  terminates the scan; sequencer returns to IDLE.
- mem_addr  out  16  pixel address to the data memory (combinational read).
- mem_rd  in  16x16  read vector from memory; lane i = pixel mem_addr+i.
- vec_data  out  16x16  registered pixel vector.
- vec_valid  out  1  vec_data holds an unconsumed chunk.
- vec_ready  in  1  consumer accepts vec_data this cycle.
- vec_row  out  16  row index of the chunk in vec_data.
- vec_col  out  16  pixel column of lane 0 of vec_data.
- vec_last  out  1  vec_data is the final chunk of the image.
- busy  out  1  high in FETCH and STREAM.
- done  out  1  one-cycle pulse after the last chunk is accepted.

Behaviour:
- Reset (async, RSTn=0):
  - State IDLE.
  - mem_addr=BASE_ADDR.
  - vec_data=0, vec_valid=0, vec_row=0, vec_col=0, vec_last=0, busy=0, done=0.
- States: IDLE, FETCH, STREAM, DONE.
- IDLE:
  - On start=1: go to FETCH. Address counter=BASE_ADDR, row=0, col=0.
  - start is ignored in every other state.
- FETCH (1 cycle):
  - mem_addr = address counter.
  - At the clock edge:
    - vec_data lanes 0..LANES-1 <= mem_rd lanes 0..LANES-1; lanes LANES..15 <= 0.
    - vec_valid<=1.
    - vec_row/vec_col/vec_last are loaded with the coordinates of this chunk.
    - The address counter advances by LANES.
    - Go to STREAM.
- STREAM:
  - mem_addr always presents the next chunk address.
  - On vec_valid&vec_ready with vec_last=0: load the next chunk in the same edge, exactly as in FETCH. Sustained throughput is 1 chunk/cycle.
  - On vec_valid&vec_ready with vec_last=1: vec_valid<=0, go to DONE.
  - With vec_ready=0: vec_data, vec_row, vec_col, vec_last and the address counter hold.
- DONE: done=1 for exactly one cycle, then IDLE.
- Coordinates:
  - col steps by LANES.
  - When col+LANES==IMAGE_WIDTH, col wraps to 0 and row increments.
  - vec_last=1 when row==IMAGE_HEIGHT-1 and col==IMAGE_WIDTH-LANES.
  - Default total: 1152 chunks. The last chunk is addressed at BASE_ADDR+9208.
- Address arithmetic: 16-bit unsigned, wraps modulo 2^16. No bounds check.
- Latency: the first vec_valid rises 2 cycles after the start pulse (start edge -> FETCH -> valid).
- abort:
  - Highest priority, effective in any state.
  - Next edge: IDLE, vec_valid=0, busy=0, no done pulse.
  - A handshake in the same cycle as abort is discarded.
  - abort with start in IDLE: stays IDLE.
- busy=1 exactly in FETCH and STREAM.
- Outputs are registered. mem_addr comes straight from the counter register (no combinational path from vec_ready).

Test Plan:
- Reset then idle: RSTn low mid-STREAM -> all outputs zero immediately, state IDLE; start=0 for 10 cycles -> vec_valid stays 0.
- Full scan with vec_ready=1, memory[i]=i mod 256:
  - 1152 handshakes, one per cycle.
  - First vector lanes 0..7 = 0..7, lanes 8..15 = 0.
  - Chunk 12 has vec_row=1, vec_col=0.
  - Last chunk has vec_row=95, vec_col=88, vec_last=1.
  - done pulses once, 1 cycle after the last handshake.
- Backpressure: vec_ready toggled 1,0,0,1,... -> no chunk lost or duplicated; vec_data and vec_col stable while vec_ready=0; total 1152 handshakes.
- Abort: abort asserted at chunk 500 with vec_ready=1 -> next cycle vec_valid=0, busy=0, done never pulses; new start restarts at vec_row=0, vec_col=0, mem_addr=BASE_ADDR.
- start while busy: start pulsed at chunk 10 -> ignored; sequence continues to chunk 11 unchanged.
- Small-image parameters: IMAGE_WIDTH=16, IMAGE_HEIGHT=2, BASE_ADDR=100 -> 4 chunks at addresses 100, 108, 116, 124; rows 0,0,1,1; cols 0,8,0,8; vec_last on the 4th chunk only.
